// File: rtl/start_fifo_pkg.sv
// Shared types and helpers for the SRL start-token FIFO read controller.
// Optional occupancy port and producer check are enabled with START_FIFO_OCC_EN.
package start_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } fifo_state_e;

    localparam int DEF_ADDR_WIDTH = 1;
    localparam int CNT_W          = DEF_ADDR_WIDTH + 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/start_fifo_srl_store.sv
// Shift-register token storage: a write shifts every token up one slot and
// lands the new token in slot 0; the read port is a plain mux on addr.
module start_fifo_srl_store
    import start_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset on purpose so the array maps onto SRL primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/start_fifo_srl_ctrl.sv
// Read-side controller for the SRL start-token FIFO: occupancy, handshake flags
// and storage read address. Define START_FIFO_OCC_EN to add num_valid and the producer check.
module start_fifo_srl_ctrl
    import start_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
`ifdef START_FIFO_OCC_EN
    ,
    output logic [ADDR_WIDTH:0]   num_valid
`endif
);

    localparam int                  CntWidth = ADDR_WIDTH + 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(DEPTH);
    localparam logic [CntWidth-1:0] OneCnt   = CntWidth'(1);

    logic [CntWidth-1:0]   cnt_q;
    logic [CntWidth-1:0]   cnt_d;
    logic                  emptyN_q;
    logic                  fullN_q;
    logic                  push;
    logic                  pop;
    fifo_state_e           state;
    logic [ADDR_WIDTH-1:0] addr;

    assign push = if_write & if_write_ce & fullN_q;
    assign pop  = if_read  & if_read_ce  & emptyN_q;

    always_comb begin
        state = PARTIAL;
        if (cnt_q == '0) begin
            state = EMPTY;
        end else if (cnt_q == DepthCnt) begin
            state = FULL;
        end
    end

    // Push and pop together only occur in PARTIAL: the shift lands the next token at the same addr.
    always_comb begin
        cnt_d = cnt_q;
        unique case (state)
            EMPTY:   if (push) cnt_d = cnt_q + OneCnt;
            PARTIAL: begin
                if (push && !pop) begin
                    cnt_d = cnt_q + OneCnt;
                end else if (pop && !push) begin
                    cnt_d = cnt_q - OneCnt;
                end
            end
            FULL:    if (pop) cnt_d = cnt_q - OneCnt;
            default: cnt_d = cnt_q;
        endcase
    end

    assign addr = (state == EMPTY) ? '0 : ADDR_WIDTH'(cnt_q - OneCnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            emptyN_q <= 1'b0;
            fullN_q  <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            emptyN_q <= (cnt_d != '0);
            fullN_q  <= (cnt_d != DepthCnt);
        end
    end

    assign if_empty_n = emptyN_q;
    assign if_full_n  = fullN_q;

    start_fifo_srl_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_store (
        .clk  (clk),
        .we   (push),
        .addr (addr),
        .din  (if_din),
        .dout (if_dout)
    );

`ifdef START_FIFO_OCC_EN
    assign num_valid = cnt_q;

    // A producer that writes into a full FIFO has broken the handshake.
    producerProtocol: assert property (@(posedge clk) disable iff (!reset_n)
        !(if_write && if_write_ce && !fullN_q));
`endif

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Bench for start_fifo_srl_ctrl: DEPTH=2 and DEPTH=4 instances share stimulus and
// are compared against queue models (num_valid checked when START_FIFO_OCC_EN is defined).
module tb_start_fifo_srl_ctrl;

    logic       clk;
    logic       reset_n;
    logic       wce;
    logic       rd;
    logic       rce;
    logic [7:0] din;
    logic       wr2;
    logic       wr4;
    logic       fullN2;
    logic       emptyN2;
    logic [7:0] dout2;
    logic       fullN4;
    logic       emptyN4;
    logic [7:0] dout4;
`ifdef START_FIFO_OCC_EN
    logic [1:0] numValid2;
    logic [2:0] numValid4;
`endif

    int checkCount;
    int errorCount;
    int q2[$];
    int q4[$];

    start_fifo_srl_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_write_ce (wce),
        .if_write    (wr2),
        .if_din      (din),
        .if_full_n   (fullN2),
        .if_read_ce  (rce),
        .if_read     (rd),
        .if_dout     (dout2),
        .if_empty_n  (emptyN2)
`ifdef START_FIFO_OCC_EN
        ,
        .num_valid   (numValid2)
`endif
    );

    start_fifo_srl_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut4 (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_write_ce (wce),
        .if_write    (wr4),
        .if_din      (din),
        .if_full_n   (fullN4),
        .if_read_ce  (rce),
        .if_read     (rd),
        .if_dout     (dout4),
        .if_empty_n  (emptyN4)
`ifdef START_FIFO_OCC_EN
        ,
        .num_valid   (numValid4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare both instances against their queue models.
    task automatic checkModels();
        checkOutput("emptyN2", 32'(emptyN2), 32'(q2.size() != 0));
        checkOutput("fullN2", 32'(fullN2), 32'(q2.size() != 2));
        if (q2.size() != 0) checkOutput("dout2", 32'(dout2), q2[0]);
        checkOutput("emptyN4", 32'(emptyN4), 32'(q4.size() != 0));
        checkOutput("fullN4", 32'(fullN4), 32'(q4.size() != 4));
        if (q4.size() != 0) checkOutput("dout4", 32'(dout4), q4[0]);
`ifdef START_FIFO_OCC_EN
        checkOutput("numValid2", 32'(numValid2), q2.size());
        checkOutput("numValid4", 32'(numValid4), q4.size());
`endif
    endtask

    // Drive one cycle of requests, let one edge pass, update models and check.
    task automatic applyStimulus(input logic w, input logic wc, input logic r, input logic rc,
                                 input logic [7:0] d);
        logic push2, push4, pop2, pop4;
        wr2 = w;
        wr4 = w;
`ifdef START_FIFO_OCC_EN
        if (q2.size() == 2) wr2 = 1'b0;
        if (q4.size() == 4) wr4 = 1'b0;
`endif
        wce = wc;
        rd  = r;
        rce = rc;
        din = d;
        push2 = wr2 && wc && (q2.size() < 2);
        push4 = wr4 && wc && (q4.size() < 4);
        pop2  = r && rc && (q2.size() > 0);
        pop4  = r && rc && (q4.size() > 0);
        @(posedge clk);
        #1;
        if (pop2) void'(q2.pop_front());
        if (push2) q2.push_back(int'(d));
        if (pop4) void'(q4.pop_front());
        if (push4) q4.push_back(int'(d));
        checkModels();
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset_n = 1'b0;
        wr2 = 1'b0;
        wr4 = 1'b0;
        wce = 1'b0;
        rd  = 1'b0;
        rce = 1'b0;
        din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst emptyN2", 32'(emptyN2), 32'd0);
        checkOutput("rst fullN2", 32'(fullN2), 32'd1);
        reset_n = 1'b1;

        // Pop attempt on an empty FIFO changes nothing.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("t1 emptyN2", 32'(emptyN2), 32'd0);

        // Fill DEPTH=2, blocked third push, drain in order.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hA1);
        checkOutput("t2 dout A1", 32'(dout2), 32'hA1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hB2);
        checkOutput("t2 fullN2", 32'(fullN2), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
        checkOutput("t2 head A1", 32'(dout2), 32'hA1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("t2 head B2", 32'(dout2), 32'hB2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("t2 emptyN2", 32'(emptyN2), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        // Simultaneous push and pop at one token.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hA1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hB2);
        checkOutput("t3 dout B2", 32'(dout2), 32'hB2);
        checkOutput("t3 fullN2", 32'(fullN2), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        // Requests without clock enables are ignored.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h88);
            checkOutput("t4 dout 77", 32'(dout2), 32'h77);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        // Fill DEPTH=4 then reset asynchronously mid-cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        end
        checkOutput("t5 fullN4", 32'(fullN4), 32'd0);
        wr2 = 1'b0;
        wr4 = 1'b0;
        wce = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("t5 async emptyN4", 32'(emptyN4), 32'd0);
        checkOutput("t5 async fullN4", 32'(fullN4), 32'd1);
        checkOutput("t5 async emptyN2", 32'(emptyN2), 32'd0);
`ifdef START_FIFO_OCC_EN
        checkOutput("t5 async numValid4", 32'(numValid4), 32'd0);
`endif
        q2.delete();
        q4.delete();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        checkOutput("t5 dout4 55", 32'(dout4), 32'h55);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        // Random traffic against the queue models.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
